// File: rtl/eclair_dev_pkg.sv
// Shared constants for the console/device bus responder: register offsets, STATUS bit
// positions and the device address window.
package eclair_dev_pkg;

  localparam logic [3:0] DEV_WINDOW = 4'b0111;

  localparam logic [1:0] DEV_REG_DATA   = 2'd0;
  localparam logic [1:0] DEV_REG_STATUS = 2'd1;
  localparam logic [1:0] DEV_REG_CTRL   = 2'd2;
  localparam logic [1:0] DEV_REG_TXLVL  = 2'd3;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_TX_EMPTY    = 2;
  localparam int unsigned ST_TX_OVF      = 3;
  localparam int unsigned ST_IRQ         = 4;

  typedef struct packed {
    logic tx_empty_irq_en;
    logic rx_irq_en;
  } dev_ctrl_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with extra-MSB pointers; dout shows the head entry whenever !empty.
// A push while full is dropped even if a pop happens in the same cycle.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign level   = wr_q - rd_q;
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d  = wr_q + {{AW{1'b0}}, do_push};
    rd_d  = rd_q + {{AW{1'b0}}, do_pop};
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bus_device_port.sv
// Console/device responder on the main data bus: CPU writes feed a TX FIFO, an external source
// feeds an RX FIFO. Define DEVICE_IRQ_EN to enable the CTRL register and the registered irq.
module bus_device_port
  import eclair_dev_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       _cs,
  input  logic       _oe,
  input  logic       _w,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  logic                        w_q, w_d, oe_q, oe_d, cs_q, cs_d;
  logic                        tx_ovf_q, tx_ovf_d;
  logic                        write_ev, pop_ev, reg_hit, tx_push, status_wr, ctrl_wr;
  logic                        tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH):0]   tx_level;
  logic [$clog2(RX_DEPTH):0]   rx_level;
  logic [7:0]                  rx_head, status;
  dev_ctrl_t                   ctrl_rd;
  logic                        unused_rx_level;

  assign unused_rx_level = ^rx_level;

  assign reg_hit   = (addr[3:2] == 2'b00);
  assign write_ev  = w_q & ~_w & ~_cs & ~reset;
  assign tx_push   = write_ev & reg_hit & (addr[1:0] == DEV_REG_DATA);
  assign status_wr = write_ev & reg_hit & (addr[1:0] == DEV_REG_STATUS);
  assign ctrl_wr   = write_ev & reg_hit & (addr[1:0] == DEV_REG_CTRL);
  // Pop on the trailing edge of the read so the byte driven during the read is the one consumed.
  assign pop_ev    = ~oe_q & _oe & ~cs_q & (addr == 4'd0) & ~rx_empty & ~reset;

  assign data_oe  = ~_cs & ~_oe & _w;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_valid & tx_ready),
    .din   (data_in),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid & rx_ready),
    .pop   (pop_ev),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_comb begin
    w_d      = _w;
    oe_d     = _oe;
    cs_d     = _cs;
    tx_ovf_d = tx_ovf_q;
    if (tx_push && tx_full) begin
      tx_ovf_d = 1'b1;
    end else if (status_wr && data_in[ST_TX_OVF]) begin
      tx_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= 1'b1;
      oe_q     <= 1'b1;
      cs_q     <= 1'b1;
      tx_ovf_q <= 1'b0;
    end else begin
      w_q      <= w_d;
      oe_q     <= oe_d;
      cs_q     <= cs_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

`ifdef DEVICE_IRQ_EN
  dev_ctrl_t ctrl_q, ctrl_d;
  logic      irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = dev_ctrl_t'(data_in[1:0]);
    irq_d = (ctrl_q.rx_irq_en & ~rx_empty) | (ctrl_q.tx_empty_irq_en & tx_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl_rd = ctrl_q;
  assign irq     = irq_q;
`else
  logic unused_ctrl_wr;
  assign unused_ctrl_wr = ctrl_wr;
  assign ctrl_rd        = '0;
  assign irq            = 1'b0;
`endif

  always_comb begin
    status                 = 8'h00;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_OVF]      = tx_ovf_q;
    status[ST_IRQ]         = irq;
  end

  always_comb begin
    data_out = 8'h00;
    if (reg_hit) begin
      unique case (addr[1:0])
        DEV_REG_DATA:   data_out = rx_empty ? 8'h00 : rx_head;
        DEV_REG_STATUS: data_out = status;
        DEV_REG_CTRL:   data_out = {6'b0, ctrl_rd};
        DEV_REG_TXLVL:  data_out = 8'(tx_level);
        default:        data_out = 8'h00;
      endcase
    end
  end

endmodule
